// File: rtl/master_link_pkg.sv
// Shared definitions for the master_link serial board-to-board link.
// State encodings for the transmit and receive machines plus the default
// frame width and bit-time divider used when the top is not overridden.
package master_link_pkg;

  localparam int ML_DATA_W_DEF = 16;
  localparam int ML_DIV_DEF    = 100;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HALF,
    RX_SHIFT
  } rx_state_e;

endpackage

// File: rtl/ml_bit_timer.sv
// Bit-time down counter shared by the transmit and receive paths.
// A load writes an arbitrary start value; while enabled the counter runs
// down to zero, pulses tc_o for that one cycle and wraps to DIV-1 so that
// consecutive terminal counts are exactly one bit-time apart.
module ml_bit_timer #(
  parameter int DIV = 100
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   load_i,
  input  logic [$clog2(DIV)-1:0] load_val_i,
  input  logic                   en_i,
  output logic                   tc_o
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: explicit load wins, otherwise count down and wrap at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d = W'(DIV - 1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Counter register, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/master_link.sv
// Master side of a strobe-framed serial link between two boards.
// TX shifts a latched word out LSB first, one bit per DIV clocks, while
// MasSlav_Sig is high. RX detects the slave's strobe edge, samples each bit
// near mid-bit and reports a good word (rx_valid) or an aborted frame (rx_err).
// Optional feature macro: MASTER_LINK_PARITY_EN adds an even-parity bit after
// the data bits in both directions; RX flags a parity mismatch with rx_err.
module master_link
  import master_link_pkg::*;
#(
  parameter int DATA_W = ML_DATA_W_DEF,
  parameter int DIV    = ML_DIV_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_send,
  output logic              tx_busy,
  output logic              MasSlav_A,
  output logic              MasSlav_Sig,
  input  logic              SlavMas_B_Attack,
  input  logic              SlavMas_Sig,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

`ifdef MASTER_LINK_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int TW = $clog2(DIV);
  localparam int CW = $clog2(NB);

  // ---------------------------------------------------------------- TX path
  tx_state_e   tx_state_q, tx_state_d;
  logic [NB-1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_bit_q, tx_bit_d;
  logic          tx_send_q;
  logic          tx_load;
  logic          tx_tc;
  logic          tx_run;
  logic [NB-1:0] tx_frame;

`ifdef MASTER_LINK_PARITY_EN
  assign tx_frame = {^tx_data, tx_data};
`else
  assign tx_frame = tx_data;
`endif

  assign tx_run = (tx_state_q == TX_SHIFT);

  ml_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk        (clk),
    .clr        (clr),
    .load_i     (tx_load),
    .load_val_i (TW'(DIV - 1)),
    .en_i       (tx_run),
    .tc_o       (tx_tc)
  );

  // TX next state: start on a tx_send rising edge only when idle, then shift one bit per bit-time
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_send && !tx_send_q) begin
          tx_state_d = TX_SHIFT;
          tx_shift_d = tx_frame;
          tx_bit_d   = '0;
          tx_load    = 1'b1;
        end
      end
      TX_SHIFT: begin
        if (tx_tc) begin
          if (tx_bit_q == CW'(NB - 1)) begin
            tx_state_d = TX_IDLE;
            tx_shift_d = '0;
            tx_bit_d   = '0;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + CW'(1);
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX registers, including the previous tx_send level used for edge detection
  always_ff @(posedge clk) begin
    if (clr) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_send_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_send_q  <= tx_send;
    end
  end

  assign tx_busy     = tx_run;
  assign MasSlav_Sig = tx_run;
  assign MasSlav_A   = tx_run && tx_shift_q[0];

  // ---------------------------------------------------------------- RX path
  rx_state_e     rx_state_q, rx_state_d;
  logic [NB-2:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          rx_sig_q;
  logic          rx_load;
  logic [TW-1:0] rx_load_val;
  logic          rx_tc;
  logic          rx_run;
  logic [NB-1:0] rx_sample;

  assign rx_run    = (rx_state_q != RX_IDLE);
  assign rx_sample = {SlavMas_B_Attack, rx_shift_q};

  ml_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk        (clk),
    .clr        (clr),
    .load_i     (rx_load),
    .load_val_i (rx_load_val),
    .en_i       (rx_run),
    .tc_o       (rx_tc)
  );

  // RX next state: half-bit delay after the strobe edge, then one sample per bit-time with abort on strobe loss
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    rx_load     = 1'b0;
    rx_load_val = '0;
    case (rx_state_q)
      RX_IDLE: begin
        if (SlavMas_Sig && !rx_sig_q) begin
          rx_state_d  = RX_HALF;
          rx_bit_d    = '0;
          rx_load     = 1'b1;
          rx_load_val = TW'(DIV / 2 - 1);
        end
      end
      RX_HALF: begin
        if (rx_tc) begin
          rx_state_d  = RX_SHIFT;
          rx_load     = 1'b1;
          rx_load_val = '0;
        end
      end
      RX_SHIFT: begin
        if (rx_tc) begin
          if (rx_bit_q == CW'(NB - 1)) begin
            rx_state_d = RX_IDLE;
            rx_bit_d   = '0;
`ifdef MASTER_LINK_PARITY_EN
            if (^rx_sample) begin
              rx_err_d = 1'b1;
            end else begin
              rx_data_d  = rx_sample[DATA_W-1:0];
              rx_valid_d = 1'b1;
            end
`else
            rx_data_d  = rx_sample[DATA_W-1:0];
            rx_valid_d = 1'b1;
`endif
          end else if (!SlavMas_Sig) begin
            rx_state_d = RX_IDLE;
            rx_bit_d   = '0;
            rx_err_d   = 1'b1;
          end else begin
            rx_shift_d = rx_sample[NB-1:1];
            rx_bit_d   = rx_bit_q + CW'(1);
          end
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX registers; the strobe history register makes a held-high strobe wait for a fresh edge
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_sig_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_sig_q   <= SlavMas_Sig;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: doc/master_link.md
MASTER_LINK -- requirements
Module: master_link

Interface
REQ-001 SHALL have parameter DATA_W, default 16, frame payload width in bits.
REQ-002 SHALL have parameter DIV, default 100, clk cycles per bit-time (even, >=4).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  DATA_W  word to send (board A).
REQ-006 SHALL have port tx_send  input  1  send request, level from load button; rising edge triggers.
REQ-007 SHALL have port tx_busy  output  1  high while a frame is being sent.
REQ-008 SHALL have port MasSlav_A  output  1  serial data to slave.
REQ-009 SHALL have port MasSlav_Sig  output  1  frame-active strobe to slave.
REQ-010 SHALL have port SlavMas_B_Attack  input  1  serial data from slave.
REQ-011 SHALL have port SlavMas_Sig  input  1  frame-active strobe from slave.
REQ-012 SHALL have port rx_data  output  DATA_W  last good received word (B_Attack).
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 SHALL have port rx_err  output  1  one-cycle pulse on aborted or bad frame.

Function
REQ-015 Frame format SHALL be: Sig high for exactly NB bit-times; data line carries bit i in bit-time i, LSB first; NB = DATA_W (plus 1 with parity, REQ-030); idle: Sig=0, data=0.
REQ-016 TX FSM SHALL have states TX_IDLE, TX_SHIFT; tx_send rising edge (registered previous level) in TX_IDLE latches tx_data into shift register, enters TX_SHIFT.
REQ-017 MasSlav_Sig and tx_busy SHALL go high the cycle after the edge is detected and stay high exactly NB*DIV cycles, then return to TX_IDLE.
REQ-018 MasSlav_A SHALL change only at bit-time boundaries; tx_data changes after latch SHALL not affect the frame in flight.
REQ-019 tx_send edges while tx_busy=1 SHALL be ignored (not queued); a level held high across frame end SHALL not retrigger.
REQ-020 RX FSM SHALL have states RX_IDLE, RX_HALF, RX_SHIFT; SlavMas_Sig rising edge in RX_IDLE enters RX_HALF.
REQ-021 RX_HALF SHALL wait DIV/2 cycles, then RX_SHIFT SHALL sample SlavMas_B_Attack then every DIV cycles until NB bits captured (mid-bit sampling).
REQ-022 After the last sample the FSM SHALL update rx_data, pulse rx_valid for one cycle, return to RX_IDLE, and wait for Sig low before accepting a new edge.
REQ-023 SlavMas_Sig low at any sample point before the last SHALL abort: rx_err pulse, rx_data unchanged, RX_IDLE.
REQ-024 TX and RX SHALL operate independently and concurrently; simultaneous tx start and rx completion SHALL both take effect.
REQ-025 rx_valid and rx_err SHALL never be high in the same cycle.

Reset
REQ-026 clr=1 SHALL force both FSMs to idle, counters 0, MasSlav_A=0, MasSlav_Sig=0, tx_busy=0, rx_data=0, rx_valid=0, rx_err=0, edge-detect registers 0.
REQ-027 clr mid-frame SHALL drop Sig the next cycle with no rx_valid/rx_err pulse; clr has priority over every other event.
REQ-028 tx_send held high through clr release SHALL trigger a frame (edge register resets to 0).

Configuration
REQ-029 Macro MASTER_LINK_PARITY_EN SHALL select parity support.
REQ-030 With it defined: TX appends even-parity bit after bit DATA_W-1 (NB=DATA_W+1); RX checks it, mismatch -> rx_err pulse, rx_data unchanged.
REQ-031 Without it: NB=DATA_W, no parity bit, rx_err only from aborts.

Structure
REQ-032 Package master_link_pkg SHALL hold tx/rx state enums and default DATA_W/DIV constants.
REQ-033 Sub-module ml_bit_timer (load, terminal-count pulse, width clog2(DIV)) SHALL be instantiated once for TX and once for RX.

Verification (DATA_W=16, DIV=4, RX fed by bench model)
REQ-034 tx_data=16'hA5C3, tx_send 0->1 -> Sig high 64 cycles, MasSlav_A bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
REQ-035 Bench frame 16'h1234 on SlavMas lines -> rx_data=16'h1234, one rx_valid pulse 2 cycles after 16th bit midpoint.
REQ-036 Bench drops SlavMas_Sig after 8 bits -> rx_err pulse, rx_data keeps prior 16'h1234.
REQ-037 tx_send pulsed again at cycle 20 of a frame, clr asserted at cycle 40 -> no second frame, Sig=0 and tx_busy=0 one cycle after clr.
REQ-038 MASTER_LINK_PARITY_EN: send 16'h0001 -> 17th bit=1; bench frame 16'h0003 with parity bit 1 -> rx_err, no rx_valid.
